uart_tx_buffered: RTL and testbench

//   Buffered UART transmitter: 6809-side writes bytes into a FIFO; block serialises them 8N1, LSB first,

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_fifo_sync.sv | 65 ++++++
 rtl/uart_tx_buffered.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit timing, frame shape and transmitter state encoding.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 4618;
  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS = 8;
  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_fifo_sync.sv
// Single-clock FIFO with registered full/empty/level flags; a push while full is ignored.
module uart_fifo_sync #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int WIDTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic              i_pop,
  output logic [WIDTH-1:0]  o_rd_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_level
);

  localparam logic [ADDR_W:0]   LEVEL_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LEVEL_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   level_q, level_d;
  logic              full_q, empty_q;
  logic              push_ok, pop_ok;

  assign push_ok = i_push && !full_q;
  assign pop_ok  = i_pop && !empty_q;

  always_comb begin
    level_d = level_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LEVEL_ONE;
      2'b01:   level_d = level_q - LEVEL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      level_q <= level_d;
      full_q  <= (level_d == LEVEL_FULL);
      empty_q <= (level_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_wr_data;
  end

  assign o_rd_data = mem_q[rd_ptr_q];
  assign o_full    = full_q;
  assign o_empty   = empty_q;
  assign o_level   = level_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 transmitter, LSB first: bytes queue in a FIFO and are sent back-to-back while enabled.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_wr_en,
  input  logic [7:0]      i_wr_data,
  input  logic            i_tx_enable,
  input  logic            i_irq_en,
  input  logic            i_clr_ovr,
  output logic            o_UART_RX,
  output logic            o_full,
  output logic            o_empty,
  output logic [ADDR_W:0] o_level,
  output logic            o_busy,
  output logic            o_overrun,
  output logic            o_IRQ,
  output tx_state_t       o_dbg_state
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);

  tx_state_t         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              line_q, line_d;
  logic              busy_q, busy_d;
  logic              ovr_q, ovr_d;
  logic              irq_q, irq_d;
  logic              pop, start_ok, baud_end;
  logic [7:0]        fifo_data;
  logic              fifo_full, fifo_empty;

  // Write side has no back-pressure: a one-cycle i_wr_en strobe is taken iff the FIFO
  // was not full before the edge; otherwise the byte is lost and o_overrun latches.
  uart_fifo_sync #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WIDTH(8)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (i_wr_en),
    .i_wr_data (i_wr_data),
    .i_pop     (pop),
    .o_rd_data (fifo_data),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty),
    .o_level   (o_level)
  );

  assign start_ok = !fifo_empty && i_tx_enable;
  assign baud_end = (baud_q == BAUD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      line_q  <= LINE_IDLE;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      irq_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      line_q  <= line_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_ok) state_d = ST_START;
      ST_START: if (baud_end) state_d = ST_DATA;
      ST_DATA:  if (baud_end && bit_q == LAST_BIT) state_d = ST_STOP;
      ST_STOP:  if (baud_end) state_d = start_ok ? ST_START : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    line_d  = line_q;
    busy_d  = busy_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        line_d = LINE_IDLE;
        busy_d = 1'b0;
        if (start_ok) begin
          pop     = 1'b1;
          shift_d = fifo_data;
          line_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_START: begin
        baud_d = baud_q + BAUD_ONE;
        if (baud_end) begin
          baud_d = '0;
          bit_d  = '0;
          line_d = shift_q[0];
        end
      end
      ST_DATA: begin
        baud_d = baud_q + BAUD_ONE;
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == LAST_BIT) begin
            line_d = LINE_IDLE;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            line_d  = shift_q[1];
          end
        end
      end
      ST_STOP: begin
        baud_d = baud_q + BAUD_ONE;
        if (baud_end) begin
          baud_d = '0;
          // Chaining straight into the next start bit keeps frames gap-free.
          if (start_ok) begin
            pop     = 1'b1;
            shift_d = fifo_data;
            line_d  = 1'b0;
          end else begin
            line_d = LINE_IDLE;
            busy_d = 1'b0;
          end
        end
      end
      default: begin
        line_d = LINE_IDLE;
        busy_d = 1'b0;
      end
    endcase

    if (i_wr_en && fifo_full) ovr_d = 1'b1;
    else if (i_clr_ovr)       ovr_d = 1'b0;
    else                      ovr_d = ovr_q;

    irq_d = !(i_irq_en && fifo_empty && state_q == ST_IDLE);
  end

  assign o_UART_RX   = line_q;
  assign o_full      = fifo_full;
  assign o_empty     = fifo_empty;
  assign o_busy      = busy_q;
  assign o_overrun   = ovr_q;
  assign o_IRQ       = irq_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: frame-position reference model, serial receiver scoreboard, vectors and corner sequences.
module tb_uart_tx_buffered;
  import uart_pkg::*;

  localparam int CPB    = 8;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;
  localparam int FRAME  = FRAME_BITS * CPB;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset;
  logic wr_en, tx_en, irq_en, clr_ovr;
  logic [7:0] wr_data;
  logic line, full, empty, busy, ovr, irq;
  logic [ADDR_W:0] level;
  tx_state_t dbg_state;

  always #5 clk = ~clk;

  uart_tx_buffered #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_wr_en     (wr_en),
    .i_wr_data   (wr_data),
    .i_tx_enable (tx_en),
    .i_irq_en    (irq_en),
    .i_clr_ovr   (clr_ovr),
    .o_UART_RX   (line),
    .o_full      (full),
    .o_empty     (empty),
    .o_level     (level),
    .o_busy      (busy),
    .o_overrun   (ovr),
    .o_IRQ       (irq),
    .o_dbg_state (dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  logic [7:0] m_q[$];
  logic       m_busy;
  int         m_t;
  logic [7:0] m_byte;
  logic       m_ovr, m_irq;

  // scoreboard: bytes accepted into the FIFO, in the order they must appear on the line
  logic [7:0] exp_q[$];
  logic       rx_active;
  int         rx_cnt;
  logic [7:0] rx_byte;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic line_at(input logic [7:0] b, input int t);
    int slot;
    slot = t / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_busy = 1'b0;
    m_t = 0;
    m_byte = 8'h00;
    m_ovr = 1'b0;
    m_irq = 1'b1;
    rx_active = 1'b0;
    rx_cnt = 0;
    rx_byte = 8'h00;
  endtask

  task automatic model_edge(input logic wr, input logic [7:0] d, input logic clr);
    logic was_full, was_empty, frame_end, can_start, irq_n;
    was_full  = (m_q.size() == DEPTH);
    was_empty = (m_q.size() == 0);
    frame_end = m_busy && (m_t == FRAME - 1);
    can_start = (!m_busy || frame_end) && !was_empty && tx_en;
    irq_n     = !(irq_en && was_empty && !m_busy);
    if (can_start) begin
      m_byte = m_q.pop_front();
      m_busy = 1'b1;
      m_t = 0;
    end else if (frame_end) begin
      m_busy = 1'b0;
      m_t = 0;
    end else if (m_busy) begin
      m_t++;
    end
    if (wr && was_full) begin
      m_ovr = 1'b1;
    end else begin
      if (wr) begin
        m_q.push_back(d);
        exp_q.push_back(d);
      end
      if (clr) m_ovr = 1'b0;
    end
    m_irq = irq_n;
  endtask

  function automatic logic [8:0] model_vec();
    logic ml;
    ml = m_busy ? line_at(m_byte, m_t) : 1'b1;
    return {ml, m_busy, m_q.size() == DEPTH, m_q.size() == 0,
            (ADDR_W+1)'(m_q.size()), m_ovr, m_irq};
  endfunction

  function automatic logic [8:0] dut_vec();
    return {line, busy, full, empty, level, ovr, irq};
  endfunction

  // serial receiver sampling mid-bit; decoded bytes are checked against exp_q
  task automatic rx_monitor();
    int k;
    logic [8:0] want;
    if (!rx_active) begin
      if (line === 1'b0) begin
        rx_active = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % CPB == CPB / 2) begin
        k = rx_cnt / CPB;
        if (k >= 1 && k <= 8) begin
          rx_byte[k-1] = line;
        end else if (k == 9) begin
          rx_active = 1'b0;
          check("rx_stop_bit", line, 1);
          want = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
          check("rx_byte", {1'b0, rx_byte}, want);
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic wr, input logic [7:0] d, input logic clr);
    wr_en = wr;
    wr_data = d;
    clr_ovr = clr;
    @(posedge clk);
    model_edge(wr, d, clr);
    #1;
    check("cycle", dut_vec(), model_vec());
    rx_monitor();
    wr_en = 1'b0;
    clr_ovr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic async_reset();
    wr_en = 1'b0;
    clr_ovr = 1'b0;
    reset = 1'b1;
    #2;
    model_reset();
    check("rst_async_vec", dut_vec(), model_vec());
    check("rst_async_line", line, 1);
    check("rst_async_level", level, 0);
    check("rst_async_busy", busy, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic            wr;
    logic [7:0]      d;
    logic            clr;
    logic [ADDR_W:0] level;
    logic            full;
    logic            empty;
    logic            ovr;
  } vec_t;

  vec_t tbl [8];
  logic [7:0] a5_bits;
  int busy_cnt, gap, irq_bad, j;

  initial begin
    tbl[0] = '{1'b1, 8'h11, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 8'h22, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 8'h33, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 8'h44, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 8'h55, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 8'h66, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0};

    reset = 1'b1;
    wr_en = 1'b0;
    wr_data = 8'h00;
    tx_en = 1'b0;
    irq_en = 1'b0;
    clr_ovr = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check("rst_vec", dut_vec(), model_vec());
    check("rst_line", line, 1);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_irq", irq, 1);
    check("rst_state", dbg_state, ST_IDLE);
    reset = 1'b0;
    idle(3);

    // fill with transmitter disabled, overflow and clear
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].wr, tbl[i].d, tbl[i].clr);
      check($sformatf("tbl%0d_level", i), level, tbl[i].level);
      check($sformatf("tbl%0d_full", i), full, tbl[i].full);
      check($sformatf("tbl%0d_empty", i), empty, tbl[i].empty);
      check($sformatf("tbl%0d_ovr", i), ovr, tbl[i].ovr);
    end
    tx_en = 1'b1;
    idle(4 * FRAME + 5);
    check("tbl_drained_level", level, 0);
    check("tbl_drained_frames", exp_q.size(), 0);

    // single 0xA5 frame: latency, bit order, busy length
    a5_bits = 8'hA5;
    step(1'b1, 8'hA5, 1'b0);
    check("a5_line_at_write", line, 1);
    step(1'b0, 8'h00, 1'b0);
    check("a5_start_low", line, 0);
    busy_cnt = busy ? 1 : 0;
    for (int i = 1; i < 90; i++) begin
      step(1'b0, 8'h00, 1'b0);
      if (busy) busy_cnt++;
      if (i % CPB == CPB / 2 && i / CPB >= 1 && i / CPB <= 8)
        check($sformatf("a5_bit%0d", i / CPB - 1), line, a5_bits[i / CPB - 1]);
      if (i == 9 * CPB + CPB / 2) check("a5_stop", line, 1);
    end
    check("a5_busy_len", busy_cnt, 80);

    // three queued bytes go out back-to-back
    tx_en = 1'b0;
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0);
    step(1'b1, 8'h03, 1'b0);
    check("b2b_level3", level, 3);
    tx_en = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    check("b2b_level2", level, 2);
    gap = 0;
    for (int i = 1; i <= 3 * FRAME; i++) begin
      step(1'b0, 8'h00, 1'b0);
      if (i == FRAME) check("b2b_level1", level, 1);
      if (i == 2 * FRAME) check("b2b_level0", level, 0);
      if (i < 3 * FRAME && !busy) gap++;
      if (i == 3 * FRAME) check("b2b_busy_end", busy, 0);
    end
    check("b2b_gap", gap, 0);

    // drain interrupt
    irq_en = 1'b1;
    idle(2);
    check("irq_idle_low", irq, 0);
    step(1'b1, 8'h5A, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    check("irq_after_write", irq, 1);
    irq_bad = 0;
    j = 1;
    while (j <= 100) begin
      step(1'b0, 8'h00, 1'b0);
      if (!busy) break;
      if (!irq) irq_bad++;
      j++;
    end
    check("irq_frame_len", j, FRAME);
    check("irq_high_in_frame", irq_bad, 0);
    check("irq_at_stop_end", irq, 1);
    step(1'b0, 8'h00, 1'b0);
    check("irq_drain_low", irq, 0);
    tx_en = 1'b0;
    step(1'b1, 8'h99, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    check("irq_new_write", irq, 1);
    tx_en = 1'b1;
    irq_en = 1'b0;
    idle(FRAME + 5);

    // enable dropped mid-frame with another byte queued
    step(1'b1, 8'hC3, 1'b0);
    step(1'b1, 8'h3C, 1'b0);
    check("en_queued", level, 1);
    idle(30);
    tx_en = 1'b0;
    idle(70);
    check("en_frame_done_line", line, 1);
    check("en_frame_done_busy", busy, 0);
    idle(20);
    check("en_hold_level", level, 1);
    check("en_hold_line", line, 1);
    tx_en = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    check("en_resume_line", line, 0);
    check("en_resume_level", level, 0);
    idle(FRAME + 5);

    // reset mid-DATA, then a clean frame
    step(1'b1, 8'h77, 1'b0);
    step(1'b1, 8'h88, 1'b0);
    idle(30);
    async_reset();
    step(1'b1, 8'h3C, 1'b0);
    idle(FRAME + 5);
    check("rst_clean_frame", exp_q.size(), 0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 2) tx_en = ~tx_en;
      if ($urandom_range(0, 99) < 2) irq_en = ~irq_en;
      step($urandom_range(0, 3) == 0, 8'($urandom()), $urandom_range(0, 15) == 0);
    end
    tx_en = 1'b1;
    idle((DEPTH + 2) * FRAME);
    check("rand_drained_level", level, 0);
    check("rand_drained_frames", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
